// File: rtl/rf_pkg.sv
// Shared widths and requester encoding for the register-file write-back arbiter.
package rf_pkg;

    localparam int unsigned DATA_W   = 64;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

    // Round-robin pointer moves to whichever requester lost the grant.
    function automatic req_e other_req(input req_e r);
        return (r == REQ_ALU) ? REQ_MEM : REQ_ALU;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request, register-file write port and hazard lookup signals.
interface regfile_wb_arbiter_if
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = rf_pkg::DATA_W,
    parameter int unsigned ADDR_W = rf_pkg::ADDR_W
);

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              iss_valid;
    logic [ADDR_W-1:0] iss_addr;
    logic [ADDR_W-1:0] hz_addr0;
    logic [ADDR_W-1:0] hz_addr1;
    logic              stall;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output iss_valid, iss_addr, hz_addr0, hz_addr1,
        input  alu_ready, mem_ready,
        input  wr_en, wr_addr, wr_data,
        input  stall
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  iss_valid, iss_addr, hz_addr0, hz_addr1,
        output alu_ready, mem_ready,
        output wr_en, wr_addr, wr_data,
        output stall
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Busy bit per architectural register with set/clear ports and two hazard lookups.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_W = rf_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rd_addr0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic              hit0,
    output logic              hit1
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Clear first so a same-cycle set on the same register wins; r0 stays idle.
    always_comb begin
        busy_d = busy_q;
        if (clr_en && (clr_addr != '0)) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en && (set_addr != '0)) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        hit0 = (rd_addr0 != '0) && busy_q[rd_addr0];
        hit1 = (rd_addr1 != '0) && busy_q[rd_addr1];
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter between ALU and load write-back into a registered regfile write port.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = rf_pkg::DATA_W,
    parameter int unsigned ADDR_W = rf_pkg::ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);

    req_e              rr_q;
    logic              alu_grant;
    logic              mem_grant;
    logic              grant;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;
    logic              grant_wr;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              hit0;
    logic              hit1;

    // A lone valid always wins; contention is settled by rr.
    always_comb begin
        alu_grant  = 1'b0;
        mem_grant  = 1'b0;
        grant_addr = bus.alu_addr;
        grant_data = bus.alu_data;
        if (!reset) begin
            alu_grant = bus.alu_valid && (!bus.mem_valid || (rr_q == REQ_ALU));
            mem_grant = bus.mem_valid && (!bus.alu_valid || (rr_q == REQ_MEM));
        end
        if (mem_grant) begin
            grant_addr = bus.mem_addr;
            grant_data = bus.mem_data;
        end
        grant    = alu_grant || mem_grant;
        grant_wr = grant && (grant_addr != '0);
    end

    assign bus.alu_ready = alu_grant;
    assign bus.mem_ready = mem_grant;

    // Writes to r0 still consume the grant but never reach the port.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rr_q      <= REQ_ALU;
        end else begin
            wr_en_q <= grant_wr;
            if (grant_wr) begin
                wr_addr_q <= grant_addr;
                wr_data_q <= grant_data;
            end
            if (grant) begin
                rr_q <= other_req(mem_grant ? REQ_MEM : REQ_ALU);
            end
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (bus.iss_valid),
        .set_addr (bus.iss_addr),
        .clr_en   (grant_wr),
        .clr_addr (grant_addr),
        .rd_addr0 (bus.hz_addr0),
        .rd_addr1 (bus.hz_addr1),
        .hit0     (hit0),
        .hit1     (hit1)
    );

    assign bus.stall = hit0 || hit1;

endmodule
